// File: rtl/alu_writeback.sv
// Registered write-back stage behind the ALU: drives the register-file write port,
// sequences the two-register multiply write, and owns the architectural status register.
module alu_writeback #(
    parameter logic [5:0] MUL_OPCODE   = 6'b101010,
    parameter logic [7:0] STATUS_RESET = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [5:0]  ex_opcode,
    input  logic [2:0]  ex_rd,
    input  logic        ex_wb_en,
    input  logic        ex_flag_en,
    input  logic [15:0] aluout1,
    input  logic [15:0] aluout2,
    input  logic [7:0]  statusregout,
    output logic        rf_we,
    output logic [2:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    output logic [7:0]  status_reg,
    output logic        fwd_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WB_LO = 2'd1,
        WB_HI = 2'd2
    } state_t;

    state_t      state, state_d;
    logic        accept;
    logic        mul_q;
    logic [2:0]  rd_q;
    logic [15:0] hi_q;
    logic        rf_we_d;
    logic [2:0]  rf_waddr_d;
    logic [15:0] rf_wdata_d;

    // The low-half write data/enable go straight into the output flops at acceptance,
    // so the WB_LO outputs are simply the registered port values.
    always_comb begin
        ex_ready   = !((state == WB_LO) && mul_q);
        accept     = ex_valid && ex_ready;
        state_d    = IDLE;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr;
        rf_wdata_d = rf_wdata;
        if (accept) begin
            state_d    = WB_LO;
            rf_we_d    = ex_wb_en;
            rf_waddr_d = ex_rd;
            rf_wdata_d = aluout1;
        end else if ((state == WB_LO) && mul_q) begin
            state_d    = WB_HI;
            rf_we_d    = 1'b1;
            rf_waddr_d = rd_q + 3'd1;
            rf_wdata_d = hi_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mul_q      <= 1'b0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            status_reg <= STATUS_RESET;
        end else begin
            state    <= state_d;
            rf_we    <= rf_we_d;
            rf_waddr <= rf_waddr_d;
            rf_wdata <= rf_wdata_d;
            if (accept) begin
                mul_q <= (ex_opcode == MUL_OPCODE) && ex_wb_en;
                if (ex_flag_en) begin
                    status_reg <= statusregout;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            rd_q <= ex_rd;
            hi_q <= aluout2;
        end
    end

    assign fwd_valid = rf_we;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback; one task per scenario.
module tb_alu_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready, ex_ready2;
    logic [5:0]  ex_opcode;
    logic [2:0]  ex_rd;
    logic        ex_wb_en;
    logic        ex_flag_en;
    logic [15:0] aluout1, aluout2;
    logic [7:0]  statusregout;
    logic        rf_we, rf_we2;
    logic [2:0]  rf_waddr, rf_waddr2;
    logic [15:0] rf_wdata, rf_wdata2;
    logic [7:0]  status_reg, status_reg2;
    logic        fwd_valid, fwd_valid2;

    int unsigned errors = 0;
    int unsigned checks = 0;

    localparam logic [5:0] MUL = 6'b101010;
    localparam logic [5:0] ADD = 6'b010001;

    always #5 clk = ~clk;

    alu_writeback dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_wb_en(ex_wb_en), .ex_flag_en(ex_flag_en),
        .aluout1(aluout1), .aluout2(aluout2), .statusregout(statusregout),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .status_reg(status_reg), .fwd_valid(fwd_valid)
    );

    alu_writeback #(.STATUS_RESET(8'h5A)) dut2 (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready2),
        .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_wb_en(ex_wb_en), .ex_flag_en(ex_flag_en),
        .aluout1(aluout1), .aluout2(aluout2), .statusregout(statusregout),
        .rf_we(rf_we2), .rf_waddr(rf_waddr2), .rf_wdata(rf_wdata2),
        .status_reg(status_reg2), .fwd_valid(fwd_valid2)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 0; ex_opcode = '0; ex_rd = '0; ex_wb_en = 0; ex_flag_en = 0;
        aluout1 = '0; aluout2 = '0; statusregout = '0;
    endtask

    task automatic drive(input logic [5:0] op, input logic [2:0] rd, input logic wb, input logic fl,
                         input logic [15:0] a1, input logic [15:0] a2, input logic [7:0] st);
        ex_valid = 1; ex_opcode = op; ex_rd = rd; ex_wb_en = wb; ex_flag_en = fl;
        aluout1 = a1; aluout2 = a2; statusregout = st;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        cyc();
        cyc();
        reset = 0;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%0b exp=0", rf_we); end
        checks++; if (status_reg !== 8'h00) begin errors++; $display("FAIL reset_status got=%h exp=00", status_reg); end
        checks++; if (status_reg2 !== 8'h5A) begin errors++; $display("FAIL reset_status_param got=%h exp=5a", status_reg2); end
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", ex_ready); end
        cyc();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_idle_we got=%0b exp=0", rf_we); end
    endtask

    task automatic test_add();
        drive(ADD, 3'd3, 1, 1, 16'h1234, 16'h0000, 8'hA2);
        cyc();
        idle_inputs();
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL add_we got=%0b exp=1", rf_we); end
        checks++; if (fwd_valid !== 1'b1) begin errors++; $display("FAIL add_fwd got=%0b exp=1", fwd_valid); end
        checks++; if (rf_waddr !== 3'd3) begin errors++; $display("FAIL add_addr got=%0d exp=3", rf_waddr); end
        checks++; if (rf_wdata !== 16'h1234) begin errors++; $display("FAIL add_data got=%h exp=1234", rf_wdata); end
        checks++; if (status_reg !== 8'hA2) begin errors++; $display("FAIL add_status got=%h exp=a2", status_reg); end
        cyc();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL add_after_we got=%0b exp=0", rf_we); end
        checks++; if (status_reg !== 8'hA2) begin errors++; $display("FAIL add_after_status got=%h exp=a2", status_reg); end
    endtask

    task automatic test_mul_wrap();
        drive(MUL, 3'd7, 1, 0, 16'hBEEF, 16'h00DE, 8'hEE);
        cyc();
        // Upstream offers an ADD while the stage is busy; it must wait for WB_HI.
        drive(ADD, 3'd4, 1, 1, 16'h4444, 16'h0000, 8'h3C);
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL mul_lo_we got=%0b exp=1", rf_we); end
        checks++; if (rf_waddr !== 3'd7) begin errors++; $display("FAIL mul_lo_addr got=%0d exp=7", rf_waddr); end
        checks++; if (rf_wdata !== 16'hBEEF) begin errors++; $display("FAIL mul_lo_data got=%h exp=beef", rf_wdata); end
        checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL mul_lo_ready got=%0b exp=0", ex_ready); end
        checks++; if (status_reg !== 8'hA2) begin errors++; $display("FAIL mul_status got=%h exp=a2", status_reg); end
        cyc();
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL mul_hi_we got=%0b exp=1", rf_we); end
        checks++; if (rf_waddr !== 3'd0) begin errors++; $display("FAIL mul_hi_addr got=%0d exp=0", rf_waddr); end
        checks++; if (rf_wdata !== 16'h00DE) begin errors++; $display("FAIL mul_hi_data got=%h exp=00de", rf_wdata); end
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL mul_hi_ready got=%0b exp=1", ex_ready); end
        checks++; if (status_reg !== 8'hA2) begin errors++; $display("FAIL held_status got=%h exp=a2", status_reg); end
        cyc();
        idle_inputs();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 3'd4 || rf_wdata !== 16'h4444)
            begin errors++; $display("FAIL held_add_write got=%0b/%0d/%h exp=1/4/4444", rf_we, rf_waddr, rf_wdata); end
        checks++; if (status_reg !== 8'h3C) begin errors++; $display("FAIL held_add_status got=%h exp=3c", status_reg); end
        cyc();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL mul_end_we got=%0b exp=0", rf_we); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_data;
        for (int unsigned i = 1; i <= 3; i++) begin
            exp_data = 16'hA000 + 16'(i);
            drive(ADD, 3'(i), 1, 0, exp_data, 16'hFFFF, 8'h00);
            checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got=%0b exp=1", i, ex_ready); end
            cyc();
            checks++; if (rf_we !== 1'b1 || rf_waddr !== 3'(i) || rf_wdata !== exp_data)
                begin errors++; $display("FAIL b2b_write%0d got=%0b/%0d/%h exp=1/%0d/%h", i, rf_we, rf_waddr, rf_wdata, i, exp_data); end
        end
        idle_inputs();
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_end got=%0b exp=1", ex_ready); end
        cyc();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL b2b_end_we got=%0b exp=0", rf_we); end
    endtask

    task automatic test_flag_only();
        drive(ADD, 3'd2, 0, 1, 16'h5555, 16'h0000, 8'h01);
        cyc();
        idle_inputs();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL flag_we got=%0b exp=0", rf_we); end
        checks++; if (status_reg !== 8'h01) begin errors++; $display("FAIL flag_status got=%h exp=01", status_reg); end
        // Multiply without write-back: no second phase, no write.
        drive(MUL, 3'd5, 0, 0, 16'h1111, 16'h2222, 8'h00);
        cyc();
        idle_inputs();
        checks++; if (rf_we !== 1'b0 || ex_ready !== 1'b1)
            begin errors++; $display("FAIL mul_nowb_lo got=%0b/%0b exp=0/1", rf_we, ex_ready); end
        cyc();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL mul_nowb_hi got=%0b exp=0", rf_we); end
        // Invalid cycle with flag update requested must not touch status.
        ex_valid = 0; ex_flag_en = 1; ex_wb_en = 1; statusregout = 8'hFF;
        cyc();
        idle_inputs();
        checks++; if (status_reg !== 8'h01 || rf_we !== 1'b0)
            begin errors++; $display("FAIL invalid_nocap got=%h/%0b exp=01/0", status_reg, rf_we); end
    endtask

    task automatic test_reset_during_mul();
        drive(MUL, 3'd5, 1, 1, 16'h1111, 16'h2222, 8'h77);
        cyc();
        idle_inputs();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 3'd5 || status_reg !== 8'h77)
            begin errors++; $display("FAIL rmul_lo got=%0b/%0d/%h exp=1/5/77", rf_we, rf_waddr, status_reg); end
        reset = 1;
        cyc();
        reset = 0;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rmul_no_hi got=%0b exp=0", rf_we); end
        checks++; if (status_reg !== 8'h00) begin errors++; $display("FAIL rmul_status got=%h exp=00", status_reg); end
        checks++; if (status_reg2 !== 8'h5A) begin errors++; $display("FAIL rmul_status_param got=%h exp=5a", status_reg2); end
        cyc();
        checks++; if (rf_we !== 1'b0 || ex_ready !== 1'b1)
            begin errors++; $display("FAIL rmul_after got=%0b/%0b exp=0/1", rf_we, ex_ready); end
        test_add();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_add();
        test_mul_wrap();
        test_back_to_back();
        test_flag_only();
        test_reset_during_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Registered write-back stage directly downstream of the ALU.
- Captures the ALU results (aluout1, aluout2, statusregout) for one accepted instruction and drives the register-file write port.
- Sequences the two-register write for multiply (low half to rd, high half to rd+1).
- Owns the architectural status register, whose output feeds the ALU's statusregin.

Parameters:
- MUL_OPCODE, 6'b101010, encoded opcode whose result is 32-bit and is written to two registers.
- STATUS_RESET, 8'h00, value loaded into the status register on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ex_valid  input  1  ALU result for the current instruction is valid this cycle.
- ex_ready  output  1  stage can accept; transfer occurs when ex_valid && ex_ready at a rising edge.
- ex_opcode  input  6  encoded opcode of the instruction.
- ex_rd  input  3  destination register index.
- ex_wb_en  input  1  instruction writes the register file.
- ex_flag_en  input  1  instruction updates the status register.
- aluout1  input  16  ALU primary result (low half for multiply).
- aluout2  input  16  ALU high half (multiply only).
- statusregout  input  8  new status value from the ALU.
- rf_we  output  1  register-file write enable.
- rf_waddr  output  3  register-file write address.
- rf_wdata  output  16  register-file write data.
- status_reg  output  8  architectural status register; connects to the ALU's statusregin.
- fwd_valid  output  1  equals rf_we; forwarding tap for the operand-select logic.

Behaviour:
- Reset (synchronous, dominates everything):
  - state=IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, status_reg=STATUS_RESET.
  - Any pending high-half write is discarded; no write occurs in the reset cycle or the cycle after.
- States: IDLE, WB_LO, WB_HI.
- Acceptance at an edge with ex_valid && ex_ready:
  - Latch rd_q=ex_rd, lo_q=aluout1, hi_q=aluout2, wb_q=ex_wb_en.
  - Latch mul_q = (ex_opcode==MUL_OPCODE) && ex_wb_en.
  - Go to WB_LO.
- Status update:
  - If ex_flag_en at acceptance, status_reg <= statusregout on that same edge.
  - The new value is visible the cycle after acceptance, concurrent with the WB_LO write.
  - Status is unchanged otherwise, including for non-accepted ex_valid.
- WB_LO:
  - rf_we=wb_q, rf_waddr=rd_q, rf_wdata=lo_q.
  - If mul_q: next state WB_HI, and ex_ready=0 this cycle.
  - Else: next state WB_LO on a new acceptance, otherwise IDLE; ex_ready=1.
- WB_HI:
  - rf_we=1, rf_waddr=rd_q+1 (3-bit wrap: rd=7 -> 0), rf_wdata=hi_q.
  - ex_ready=1; next state WB_LO on acceptance, else IDLE.
- IDLE: rf_we=0, ex_ready=1.
- Outputs rf_we, rf_waddr and rf_wdata are registered (driven from flops).
- Latency: the write appears exactly 1 cycle after acceptance (low half); the multiply high half appears 2 cycles after.
- Throughput:
  - 1 instruction/cycle for non-multiply ops.
  - Multiply occupies 2 cycles.
  - Back-to-back non-multiply instructions produce a write every cycle with no bubble.
- Multiply with ex_wb_en=0: treated as non-multiply (mul_q=0), so no WB_HI phase and no write.
- ex_valid=0 with ex_ready=1: no state capture, and status is not modified.
- Inputs presented while ex_ready=0: ignored; the upstream stage must hold them. This stage does not buffer a second instruction.
- When rf_we=0, rf_waddr and rf_wdata hold their last value. The bench must not check them.

Test Plan:
- Reset behaviour: assert reset for 2 cycles, then release -> rf_we=0 and status_reg=8'h00. Set STATUS_RESET=8'h5A -> status_reg=8'h5A after reset.
- Single ADD: ex_valid=1, ex_opcode=6'b010001, ex_rd=3, ex_wb_en=1, ex_flag_en=1, aluout1=16'h1234, statusregout=8'hA2 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=16'h1234, status_reg=8'hA2; the following cycle rf_we=0.
- Multiply with wrap: ex_opcode=MUL_OPCODE, ex_rd=7, aluout1=16'hBEEF, aluout2=16'h00DE, ex_wb_en=1 -> cycle+1 writes r7=16'hBEEF with ex_ready=0; cycle+2 writes r0=16'h00DE with ex_ready=1.
- Back-to-back stream: three ADDs on consecutive cycles to rd=1,2,3 -> three consecutive writes, with ex_ready held at 1 throughout.
- Flag-only op: ex_wb_en=0, ex_flag_en=1, statusregout=8'h01 -> rf_we stays 0; status_reg=8'h01 one cycle later.
- Reset during multiply: assert reset in the WB_LO cycle of a multiply -> no WB_HI write; status_reg=STATUS_RESET; after reset releases, an ADD behaves as in scenario 2.
